// File: rtl/letreiro_pkg.sv
// Shared types and helpers for the scrolling-marquee engine: mode encodings,
// controller states and the compare-subtract modulo adder.
package letreiro_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_ALT   = 2'b11
    } mode_t;

    typedef logic [0:0] state_t;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    // (a + b) mod n for a < n and b <= n; a single conditional subtract, no divider.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/letreiro_scan_timer.sv
// Row-dwell prescaler, row counter and frame counter; produces the row index,
// the end-of-frame pulse and the scroll-step pulse. Held at zero while run is low.
module letreiro_scan_timer #(
    parameter int ROWS       = 5,
    parameter int SCAN_DIV   = 1000,
    parameter int SCROLL_DIV = 50,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          run,
    output logic [RW-1:0] row,
    output logic          dwell_start,
    output logic          frame_tick,
    output logic          scroll_step
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [PW-1:0] presc_reg;
    logic [RW-1:0] row_reg;
    logic [FW-1:0] frame_reg;
    logic          presc_wrap;
    logic          row_wrap;

    assign presc_wrap  = (presc_reg == PW'(SCAN_DIV - 1));
    assign row_wrap    = (row_reg == RW'(ROWS - 1));
    assign frame_tick  = run && presc_wrap && row_wrap;
    assign scroll_step = frame_tick && (frame_reg == FW'(SCROLL_DIV - 1));
    assign dwell_start = run && (presc_reg == '0);
    assign row         = row_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_reg <= '0;
            row_reg   <= '0;
            frame_reg <= '0;
        end else if (!run) begin
            presc_reg <= '0;
            row_reg   <= '0;
            frame_reg <= '0;
        end else begin
            if (presc_wrap) begin
                presc_reg <= '0;
                row_reg   <= row_wrap ? '0 : row_reg + RW'(1);
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end
            if (scroll_step) begin
                frame_reg <= '0;
            end else if (frame_tick) begin
                frame_reg <= frame_reg + FW'(1);
            end
        end
    end

endmodule

// File: rtl/letreiro_scroll_ctrl.sv
// Scrolling-marquee engine: column message buffer, clear/run controller and
// registered row/column drive. Define LETREIRO_BLINK_EN to make mode 11 blink.
module letreiro_scroll_ctrl
    import letreiro_pkg::*;
#(
    parameter int ROWS       = 5,
    parameter int COLS       = 7,
    parameter int MSG_COLS   = 32,
    parameter int SCAN_DIV   = 1000,
    parameter int SCROLL_DIV = 50,
    localparam int AW = (MSG_COLS > 1) ? $clog2(MSG_COLS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [1:0]      mode,
    input  logic            clr,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [AW-1:0]   wr_addr,
    input  logic [ROWS-1:0] wr_data,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_out,
    output logic            frame_tick
);
    state_t          state_reg;
    logic [AW-1:0]   clr_ptr_reg;
    logic [AW-1:0]   offset_reg;
    logic [ROWS-1:0] mem [MSG_COLS];
    logic [ROWS-1:0] row_sel_reg;
    logic [COLS-1:0] col_reg;
    logic [COLS-1:0] col_next;
    logic [RW-1:0]   row;
    logic            run;
    logic            dwell_start;
    logic            scroll_step;

    assign run      = (state_reg == RUN) && !clr;
    assign wr_ready = run;
    assign row_sel  = row_sel_reg;

    letreiro_scan_timer #(
        .ROWS       (ROWS),
        .SCAN_DIV   (SCAN_DIV),
        .SCROLL_DIV (SCROLL_DIV)
    ) u_scan_timer (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .run         (run),
        .row         (row),
        .dwell_start (dwell_start),
        .frame_tick  (frame_tick),
        .scroll_step (scroll_step)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
        end else if (clr) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
        end else if (state_reg == CLEAR) begin
            if (clr_ptr_reg == AW'(MSG_COLS - 1)) begin
                state_reg <= RUN;
            end else begin
                clr_ptr_reg <= clr_ptr_reg + AW'(1);
            end
        end
    end

    // Addresses past the buffer end are handshaken but discarded.
    always_ff @(posedge CLK) begin
        if (state_reg == CLEAR) begin
            mem[clr_ptr_reg] <= '0;
        end else if (wr_valid && wr_ready && ({1'b0, wr_addr} < (AW+1)'(MSG_COLS))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            offset_reg <= '0;
        end else if (!run) begin
            offset_reg <= '0;
        end else if (scroll_step) begin
            case (mode_t'(mode))
                MODE_LEFT:  offset_reg <= AW'(wrap_add(32'(offset_reg), 1, MSG_COLS));
                MODE_RIGHT: offset_reg <= (offset_reg == '0) ? AW'(MSG_COLS - 1)
                                                             : offset_reg - AW'(1);
                default:    offset_reg <= offset_reg;
            endcase
        end
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        logic [AW-1:0] col_idx;
        assign col_idx      = AW'(wrap_add(32'(offset_reg), 32'(gi), MSG_COLS));
        assign col_next[gi] = mem[col_idx][row];
    end

    // Latched once per row dwell so a mid-dwell write never tears the row.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_sel_reg <= '0;
            col_reg     <= '0;
        end else if (!run) begin
            row_sel_reg <= '0;
            col_reg     <= '0;
        end else if (dwell_start) begin
            row_sel_reg <= ROWS'(1) << row;
            col_reg     <= col_next;
        end
    end

`ifdef LETREIRO_BLINK_EN
    logic blank_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blank_reg <= 1'b0;
        end else if (!run || (mode != MODE_ALT)) begin
            blank_reg <= 1'b0;
        end else if (scroll_step) begin
            blank_reg <= ~blank_reg;
        end
    end

    assign col_out = (blank_reg && (mode == MODE_ALT)) ? '0 : col_reg;
`else
    assign col_out = col_reg;
`endif

endmodule

// File: tb/tb_letreiro_scroll_ctrl.sv
// Self-checking bench for letreiro_scroll_ctrl: frame-level reference model plus
// directed scenarios with hand-computed display values.
module tb_letreiro_scroll_ctrl;
    localparam int ROWS  = 5;
    localparam int COLS  = 7;
    localparam int MSG   = 32;
    localparam int SD    = 4;
    localparam int SCR   = 2;
    localparam int FRAME = SD * ROWS;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic            clr = 1'b0;
    logic            wr_valid = 1'b0;
    logic [4:0]      wr_addr = '0;
    logic [ROWS-1:0] wr_data = '0;
    logic            wr_ready;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_out;
    logic            frame_tick;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    letreiro_scroll_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .MSG_COLS(MSG), .SCAN_DIV(SD), .SCROLL_DIV(SCR)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .mode(mode), .clr(clr), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .row_sel(row_sel), .col_out(col_out), .frame_tick(frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts cycles spent running since the last clear, so
    // row, dwell position and frame number all follow by plain division.
    logic [ROWS-1:0] m_mem [MSG];
    bit              m_run = 0;
    int              clear_left = MSG;
    int              k = 0;
    int              m_off = 0;
    int              m_r;
    logic [ROWS-1:0] m_row_sel = '0;
    logic [COLS-1:0] m_col = '0;
    bit              m_blank = 0;

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_run = 0; clear_left = MSG; k = 0; m_off = 0;
            m_row_sel = '0; m_col = '0; m_blank = 0;
            for (int i = 0; i < MSG; i++) m_mem[i] = '0;
        end else begin
            if (!(m_run && !clr)) begin
                m_row_sel = '0; m_col = '0;
            end else if (k % SD == 0) begin
                m_r = (k / SD) % ROWS;
                m_row_sel = ROWS'(1) << m_r;
                for (int c = 0; c < COLS; c++) m_col[c] = m_mem[(m_off + c) % MSG][m_r];
            end
            if (!m_run) begin
                m_blank = 0;
                if (clr) clear_left = MSG;
                else begin
                    clear_left--;
                    if (clear_left == 0) begin m_run = 1; k = 0; end
                end
            end else if (clr) begin
                m_run = 0; clear_left = MSG; m_off = 0; k = 0; m_blank = 0;
                for (int i = 0; i < MSG; i++) m_mem[i] = '0;
            end else begin
                if (wr_valid && (int'(wr_addr) < MSG)) m_mem[wr_addr] = wr_data;
                if (mode != 2'b11) m_blank = 0;
                if ((k + 1) % FRAME == 0 && ((k + 1) / FRAME) % SCR == 0) begin
                    if (mode == 2'b01) m_off = (m_off + 1) % MSG;
                    else if (mode == 2'b10) m_off = (m_off + MSG - 1) % MSG;
`ifdef LETREIRO_BLINK_EN
                    else if (mode == 2'b11) m_blank = !m_blank;
`endif
                end
                k++;
            end
        end
    end

    always @(negedge CLK) begin
        check("wr_ready", 32'(wr_ready), 32'(m_run && !clr));
        check("frame_tick", 32'(frame_tick), 32'(m_run && !clr && ((k + 1) % FRAME == 0)));
        check("row_sel", 32'(row_sel), 32'(m_row_sel));
        check("col_out", 32'(col_out), (m_blank && mode == 2'b11) ? 32'd0 : 32'(m_col));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write(input int a, input logic [ROWS-1:0] d);
        wr_valid = 1'b1; wr_addr = 5'(a); wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_row(input int r);
        int n = 0;
        do begin @(negedge CLK); n++; end
        while (row_sel !== (ROWS'(1) << r) && n < 100);
        if (n >= 100) check("row_timeout", 32'(row_sel), 32'(ROWS'(1) << r));
    endtask

    task automatic wait_step();
        int n = 0;
        do begin @(negedge CLK); n++; end
        while (!(frame_tick === 1'b1 && ((k + 1) / FRAME) % SCR == 0) && n < 200);
        if (n >= 200) check("step_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_until_ready(input string name);
        int n = 0;
        while (wr_ready !== 1'b1 && n < 100) begin tick(); n++; end
        check(name, 32'(n), 32'd32);
    endtask

    initial begin
        int n;
        logic [COLS-1:0] v1, v2;
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [COLS-1:0] v1, v2;
        // reset state
        repeat (2) @(negedge CLK);
        check("rst_row_sel", 32'(row_sel), 32'd0);
        check("rst_col_out", 32'(col_out), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);
        tick();
        RST_N = 1'b1;
        count_until_ready("clear_len_reset");

        // static pattern, mode hold
        for (int a = 0; a < 7; a++) write(a, 5'b11111);
        n = 0;
        do begin @(negedge CLK); n++; end while (frame_tick !== 1'b1 && n < 100);
        for (int r = 0; r < ROWS; r++) begin
            wait_row(r);
            check("static_row", 32'(row_sel), 32'(ROWS'(1) << r));
            check("static_col", 32'(col_out), 32'h7F);
        end
        n = 0;
        do begin @(negedge CLK); n++; end while (frame_tick !== 1'b1 && n < 100);
        n = 0;
        do begin @(negedge CLK); n++; end while (frame_tick !== 1'b1 && n < 100);
        check("frame_period", 32'(n), 32'd20);

        // scroll left by one
        tick();
        write(7, 5'b00001);
        mode = 2'b01;
        wait_step();
        wait_row(0);
        check("left_off", 32'(m_off), 32'd1);
        check("left_row0", 32'(col_out), 32'h7F);
        wait_row(1);
        check("left_row1", 32'(col_out), 32'h3F);
        tick();
        mode = 2'b00;

        // clear with a simultaneous write
        tick();
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 5'b11111;
        @(negedge CLK);
        check("clr_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        clr = 1'b0; wr_valid = 1'b0;
        count_until_ready("clear_len_clr");
        check("clr_off", 32'(m_off), 32'd0);
        wait_row(0);
        check("clr_row0", 32'(col_out), 32'h00);

        // scroll right from offset 0 wraps to 31
        tick();
        write(31, 5'b00011);
        write(0, 5'b00001);
        mode = 2'b10;
        wait_step();
        wait_row(0);
        check("right_off", 32'(m_off), 32'd31);
        check("right_row0", 32'(col_out), 32'h03);
        wait_row(1);
        check("right_row1", 32'(col_out), 32'h01);
        tick();
        mode = 2'b00;

        // mode 11: blink when enabled, steady otherwise
        tick();
        for (int a = 0; a < MSG; a++) write(a, 5'b11111);
        mode = 2'b11;
        wait_step();
        wait_row(0);
        v1 = col_out;
        wait_step();
        wait_row(0);
        v2 = col_out;
        check("alt_off", 32'(m_off), 32'd31);
`ifdef LETREIRO_BLINK_EN
        check("blink_alt", 32'(v1 ^ v2), 32'h7F);
`else
        check("steady_a", 32'(v1), 32'h7F);
        check("steady_b", 32'(v2), 32'h7F);
`endif
        tick();
        mode = 2'b00;
        repeat (FRAME) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
